spectrum_frame_packer: RTL and testbench

//   Sits directly downstream of the FFT core. Converts each complex FFT output bin to an

---
 rtl/spectrum_frame_packer.sv | 160 ++++++++++++++++
 tb/tb_spectrum_frame_packer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spectrum_frame_packer.sv
// rtl/spectrum_frame_packer.sv - FFT bin magnitude-squared frame buffer and byte packetiser
// Captures one frame of |bin|^2 values, then streams SYNC0 SYNC1 CNT payload CSUM.
module spectrum_frame_packer #(
   parameter int         BIN_COUNT = 64,
   parameter int         IW        = 11,
   parameter logic [7:0] SYNC0     = 8'hA5,
   parameter logic [7:0] SYNC1     = 8'h5A
) (
   input  logic            sys_clock,
   input  logic            reset,
   input  logic            i_sample_valid,
   input  logic            i_frame_start,
   input  logic [2*IW-1:0] i_fft_data,
   output logic [7:0]      o_byte,
   output logic            o_byte_valid,
   input  logic            i_byte_ready,
   output logic            o_busy,
   output logic            o_frame_dropped
);

   localparam int              IDXW     = $clog2(BIN_COUNT);
   localparam logic [IDXW-1:0] LAST_BIN = IDXW'(BIN_COUNT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CAPTURE, S_SYNC0, S_SYNC1, S_CNT, S_PAYLOAD, S_CSUM
   } state_t;

   state_t            state, next_state;
   logic [IDXW-1:0]   idx;
   logic [1:0]        byte_sel;
   logic [7:0]        csum;
   logic [7:0]        frame_cnt;
   logic [23:0]       bin_mem [BIN_COUNT];
   logic              wr_en;
   logic [IDXW-1:0]   wr_addr;
   logic [7:0]        payload_byte;

   logic signed [IW-1:0]   re, im;
   logic signed [2*IW-1:0] re_ext, im_ext, re_sq, im_sq;
   logic [23:0]            mag;

   wire start_strobe = i_sample_valid & i_frame_start;
   wire xfer         = o_byte_valid & i_byte_ready;

   // Both squares are non-negative, so their unsigned sum cannot overflow 2*IW bits.
   assign re     = i_fft_data[2*IW-1:IW];
   assign im     = i_fft_data[IW-1:0];
   assign re_ext = (2*IW)'(re);
   assign im_ext = (2*IW)'(im);
   assign re_sq  = re_ext * re_ext;
   assign im_sq  = im_ext * im_ext;
   assign mag    = 24'($unsigned(re_sq)) + 24'($unsigned(im_sq));

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = idx;
      if (state == S_IDLE && start_strobe) begin
         wr_en   = 1'b1;
         wr_addr = '0;
      end else if (state == S_CAPTURE && i_sample_valid) begin
         wr_en   = 1'b1;
         wr_addr = i_frame_start ? '0 : idx;
      end
   end

   always_ff @(posedge sys_clock) begin
      if (wr_en)
         bin_mem[wr_addr] <= mag;
   end

   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:    if (start_strobe) next_state = S_CAPTURE;
         S_CAPTURE: if (i_sample_valid && !i_frame_start && idx == LAST_BIN) next_state = S_SYNC0;
         S_SYNC0:   if (xfer) next_state = S_SYNC1;
         S_SYNC1:   if (xfer) next_state = S_CNT;
         S_CNT:     if (xfer) next_state = S_PAYLOAD;
         S_PAYLOAD: if (xfer && byte_sel == 2'd0 && idx == LAST_BIN) next_state = S_CSUM;
         S_CSUM:    if (xfer) next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   always_comb begin
      case (byte_sel)
         2'd2:    payload_byte = bin_mem[idx][23:16];
         2'd1:    payload_byte = bin_mem[idx][15:8];
         default: payload_byte = bin_mem[idx][7:0];
      endcase
   end

   always_comb begin
      o_busy       = (state != S_IDLE);
      o_byte_valid = 1'b0;
      o_byte       = 8'h00;
      case (state)
         S_SYNC0:   begin o_byte_valid = 1'b1; o_byte = SYNC0;        end
         S_SYNC1:   begin o_byte_valid = 1'b1; o_byte = SYNC1;        end
         S_CNT:     begin o_byte_valid = 1'b1; o_byte = frame_cnt;    end
         S_PAYLOAD: begin o_byte_valid = 1'b1; o_byte = payload_byte; end
         S_CSUM:    begin o_byte_valid = 1'b1; o_byte = csum;         end
         default:   ;
      endcase
   end

   // Bin index doubles as write pointer while capturing and read pointer while sending;
   // it wraps to 0 at the last bin because BIN_COUNT is a power of two.
   always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
         idx             <= '0;
         byte_sel        <= 2'd2;
         csum            <= 8'h00;
         frame_cnt       <= 8'h00;
         o_frame_dropped <= 1'b0;
      end else begin
         o_frame_dropped <= 1'b0;
         if (state == S_IDLE) begin
            byte_sel <= 2'd2;
            if (start_strobe)
               idx <= IDXW'(1);
         end else if (state == S_CAPTURE) begin
            if (i_sample_valid) begin
               if (i_frame_start) begin
                  idx             <= IDXW'(1);
                  o_frame_dropped <= 1'b1;
               end else begin
                  idx <= idx + IDXW'(1);
               end
            end
         end else begin
            if (start_strobe)
               o_frame_dropped <= 1'b1;
            if (xfer) begin
               if (state == S_CNT)
                  csum <= frame_cnt;
               if (state == S_PAYLOAD) begin
                  csum <= csum ^ payload_byte;
                  if (byte_sel == 2'd0) begin
                     byte_sel <= 2'd2;
                     idx      <= idx + IDXW'(1);
                  end else begin
                     byte_sel <= byte_sel - 2'd1;
                  end
               end
               if (state == S_CSUM)
                  frame_cnt <= frame_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spectrum_frame_packer.sv
// tb/tb_spectrum_frame_packer.sv - self-checking bench for spectrum_frame_packer
// Directed bin vectors with hand-computed magnitudes, BIN_COUNT=4, IW=11.
module tb_spectrum_frame_packer;

   localparam int BINS = 4;
   localparam int IW   = 11;
   localparam int PLEN = 4 + 3 * BINS;

   logic          sys_clock = 1'b0;
   logic          reset = 1'b1;
   logic          i_sample_valid = 1'b0;
   logic          i_frame_start = 1'b0;
   logic [2*IW-1:0] i_fft_data = '0;
   logic [7:0]    o_byte;
   logic          o_byte_valid;
   logic          i_byte_ready = 1'b1;
   logic          o_busy;
   logic          o_frame_dropped;

   spectrum_frame_packer #(.BIN_COUNT(BINS), .IW(IW), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
      .sys_clock       (sys_clock),
      .reset           (reset),
      .i_sample_valid  (i_sample_valid),
      .i_frame_start   (i_frame_start),
      .i_fft_data      (i_fft_data),
      .o_byte          (o_byte),
      .o_byte_valid    (o_byte_valid),
      .i_byte_ready    (i_byte_ready),
      .o_busy          (o_busy),
      .o_frame_dropped (o_frame_dropped)
   );

   always #5 sys_clock = ~sys_clock;

   typedef struct {
      logic signed [IW-1:0] re;
      logic signed [IW-1:0] im;
      logic [23:0]          mag;
   } vec_t;

   vec_t       tbl [12];
   logic [7:0] got [$];
   logic [7:0] expq [$];
   logic [7:0] lit [PLEN];
   logic [7:0] exp_cnt;
   int         errors = 0;
   int         checks = 0;
   int         drop_cnt = 0;
   int         cyc;

   always @(negedge sys_clock)
      if (o_frame_dropped === 1'b1) drop_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clock);
      #1;
   endtask

   task automatic send_bins(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         i_sample_valid = 1'b1;
         i_frame_start  = (i == 0);
         i_fft_data     = {tbl[base+i].re, tbl[base+i].im};
         tick();
      end
      i_sample_valid = 1'b0;
      i_frame_start  = 1'b0;
   endtask

   // Collects n transferred bytes; rnd toggles ready and verifies held bytes during stalls.
   task automatic collect(input int n, input bit rnd, output int cycles);
      logic       stalled;
      logic [7:0] held;
      stalled = 1'b0;
      held    = 8'h00;
      cycles  = 0;
      got.delete();
      while (got.size() < n && cycles < 2000) begin
         i_byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stalled) begin
            check("stall_valid", {31'd0, o_byte_valid}, 32'd1);
            check("stall_byte", {24'd0, o_byte}, {24'd0, held});
         end
         if (o_byte_valid && i_byte_ready) got.push_back(o_byte);
         else if (!rnd && !o_byte_valid) check("no_gap", 32'd0, 32'd1);
         stalled = o_byte_valid & ~i_byte_ready;
         held    = o_byte;
         tick();
         cycles++;
      end
      i_byte_ready = 1'b1;
      if (got.size() < n) check("collect_timeout", got.size(), n);
   endtask

   task automatic build_expected(input int base, input logic [7:0] cnt);
      logic [7:0] cs, b;
      expq.delete();
      expq.push_back(8'hA5);
      expq.push_back(8'h5A);
      expq.push_back(cnt);
      cs = cnt;
      for (int i = 0; i < BINS; i++)
         for (int k = 2; k >= 0; k--) begin
            b = tbl[base+i].mag[8*k +: 8];
            expq.push_back(b);
            cs = cs ^ b;
         end
      expq.push_back(cs);
   endtask

   task automatic compare_packet(input string name);
      check({name, "_len"}, got.size(), expq.size());
      for (int i = 0; i < expq.size() && i < got.size(); i++)
         check($sformatf("%s_b%0d", name, i), {24'd0, got[i]}, {24'd0, expq[i]});
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      exp_cnt = 8'h00;
   endtask

   initial begin
      int c;
      int d0;
      tbl[0]  = '{ 11'sd3,     -11'sd4,    24'h000019};
      tbl[1]  = '{ 11'sd0,      11'sd0,    24'h000000};
      tbl[2]  = '{-11'sd1024,  -11'sd1024, 24'h200000};
      tbl[3]  = '{ 11'sd1,      11'sd1,    24'h000002};
      tbl[4]  = '{ 11'sd1023,   11'sd1023, 24'h1FF002};
      tbl[5]  = '{-11'sd1024,   11'sd0,    24'h100000};
      tbl[6]  = '{ 11'sd5,      11'sd12,   24'h0000A9};
      tbl[7]  = '{-11'sd7,     -11'sd24,   24'h000271};
      tbl[8]  = '{ 11'sd100,   -11'sd200,  24'h00C350};
      tbl[9]  = '{-11'sd1,      11'sd0,    24'h000001};
      tbl[10] = '{ 11'sd0,     -11'sd1024, 24'h100000};
      tbl[11] = '{-11'sd1024,   11'sd1023, 24'h1FF801};
      lit = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h19, 8'h00, 8'h00,
              8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h3B};

      #2;
      check("rst_valid", {31'd0, o_byte_valid}, 32'd0);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_byte", {24'd0, o_byte}, 32'd0);
      check("rst_dropped", {31'd0, o_frame_dropped}, 32'd0);
      do_reset();

      // Reference frame, ready tied high: exact literal bytes in 16 cycles.
      send_bins(0, BINS);
      collect(PLEN, 1'b0, c);
      check("t1_cycles", c, PLEN);
      for (int i = 0; i < PLEN; i++)
         check($sformatf("t1_b%0d", i), {24'd0, got[i]}, {24'd0, lit[i]});
      check("t1_idle", {31'd0, o_busy}, 32'd0);
      exp_cnt++;

      // Same frame under back-pressure.
      send_bins(0, BINS);
      collect(PLEN, 1'b1, c);
      build_expected(0, exp_cnt);
      compare_packet("t2");
      exp_cnt++;

      for (int f = 1; f < 3; f++) begin
         send_bins(4 * f, BINS);
         collect(PLEN, 1'b0, c);
         build_expected(4 * f, exp_cnt);
         compare_packet($sformatf("tbl%0d", f));
         exp_cnt++;
      end

      // Restart after two bins: only the second frame is sent.
      d0 = drop_cnt;
      send_bins(4, 2);
      send_bins(8, BINS);
      collect(PLEN, 1'b0, c);
      build_expected(8, exp_cnt);
      compare_packet("t4");
      check("t4_drops", drop_cnt - d0, 1);
      exp_cnt++;

      // Frame start while stalled in SYNC0.
      d0 = drop_cnt;
      send_bins(0, BINS);
      i_byte_ready = 1'b0;
      tick();
      tick();
      i_sample_valid = 1'b1;
      i_frame_start  = 1'b1;
      i_fft_data     = {tbl[4].re, tbl[4].im};
      tick();
      i_sample_valid = 1'b0;
      i_frame_start  = 1'b0;
      check("t5_pulse", {31'd0, o_frame_dropped}, 32'd1);
      check("t5_hold", {24'd0, o_byte}, 32'hA5);
      tick();
      check("t5_pulse_end", {31'd0, o_frame_dropped}, 32'd0);
      collect(PLEN, 1'b0, c);
      build_expected(0, exp_cnt);
      compare_packet("t5");
      check("t5_drops", drop_cnt - d0, 1);
      exp_cnt++;

      // Asynchronous reset in PAYLOAD aborts the packet.
      send_bins(8, BINS);
      collect(6, 1'b0, c);
      #2;
      reset = 1'b1;
      #1;
      check("t6_valid", {31'd0, o_byte_valid}, 32'd0);
      check("t6_busy", {31'd0, o_busy}, 32'd0);
      tick();
      reset = 1'b0;
      tick();
      exp_cnt = 8'h00;
      check("t6_idle_valid", {31'd0, o_byte_valid}, 32'd0);
      send_bins(0, BINS);
      collect(PLEN, 1'b0, c);
      for (int i = 0; i < PLEN; i++)
         check($sformatf("t6_b%0d", i), {24'd0, got[i]}, {24'd0, lit[i]});

      // 257 frames: counter runs 00..FF then wraps to 00.
      do_reset();
      for (int f = 0; f < 257; f++) begin
         send_bins(4 * (f % 3), BINS);
         collect(PLEN, 1'b0, c);
         build_expected(4 * (f % 3), exp_cnt);
         check($sformatf("t3_cnt%0d", f), {24'd0, got[2]}, f % 256);
         check($sformatf("t3_csum%0d", f), {24'd0, got[PLEN-1]}, {24'd0, expq[PLEN-1]});
         exp_cnt++;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
